td4_sequencer: RTL and testbench
================================

// Module: td4_sequencer
// PURPOSE
//  Fetch/decode/execute control stage for the 4-bit CPU; sits directly upstream of the
//  register blocks (A, B, OUT). Owns the program counter, instruction register, 4-bit adder
//  and carry flag. Drives the register-block data input and one-cycle load strobes.
//  Multi-cycle: every instruction takes exactly 3 clocks (FETCH, DECODE, EXEC).
// PARAMETERS
//  ADDR_W   4   program counter / ROM address width
//  DATA_W   4   datapath width (registers, immediate, adder)
// PORTS
//  clk       in   1       system clock, all state updates on posedge
//  clr       in   1       reset, synchronous, active-high (shared with register blocks)
//  run       in   1       1 = sequence instructions; 0 = hold in FETCH
//  rom_data  in   8       instruction word {opcode[7:4], imm[3:0]}, combinational ROM at rom_addr
//  reg_a     in   4       current A register value
//  reg_b     in   4       current B register value
//  in_port   in   4       external input port
//  rom_addr  out  4       program counter
//  alu_out   out  4       registered adder result, to register-block 'in'
//  load_a    out  1       load strobe to register A (one cycle, EXEC only)
//  load_b    out  1       load strobe to register B
//  load_out  out  1       load strobe to output register
//  carry     out  1       carry flag
//  state     out  2       FSM state: 00 FETCH, 01 DECODE, 10 EXEC (11 unused)
// BEHAVIOUR
//  Reset: clr=1 at posedge -> state=FETCH, pc=0, ir=8'h00, alu_out=0, carry=0, all loads=0.
//   clr wins over every other event; clr mid-instruction aborts it, no load strobe is issued.
//  FSM, transitions:
//   FETCH:  if run, ir<=rom_data, ->DECODE; else stay, nothing changes.
//   DECODE: select src, sum = {1'b0,src}+{1'b0,imm} (5 bits); alu_out<=sum[3:0];
//           cy_next<=sum[4]; set the decoded load_* reg to 1; ->EXEC.
//   EXEC:   load_* high this cycle only (registers capture alu_out at the edge ending EXEC);
//           load_*<=0; carry<=cy_next; pc update; ->FETCH.
//  Decode (opcode: op, src, destination load):
//   0000 ADD A,Im  src=A     load_a  |  0101 ADD B,Im  src=B     load_b
//   0011 MOV A,Im  src=0     load_a  |  0111 MOV B,Im  src=0     load_b
//   0001 MOV A,B   src=B     load_a  |  0100 MOV B,A   src=A     load_b
//   0010 IN A      src=in    load_a  |  0110 IN B      src=in    load_b
//   1001 OUT B     src=B     load_out|  1011 OUT Im    src=0     load_out
//   1111 JMP Im    src=0     none    |  1110 JNC Im    src=0     none
//   all others: NOP, src=0, no load; imm is always added (TD4 semantics).
//  Carry: updated in EXEC for every instruction from sum[4]; JMP/JNC/NOP therefore clear it.
//  PC: JMP -> pc<=imm; JNC -> pc<=imm if carry==0 (flag value before this EXEC), else pc+1;
//   otherwise pc<=pc+1, 4-bit wrap 15->0.
//  Exactly one of load_a/load_b/load_out high at most, and only while state==EXEC.
//  run sampled only in FETCH; dropping run during DECODE/EXEC completes current instruction.
//  src/in_port/reg_* sampled in DECODE only.
// TESTING
//  1 clr=1 two cycles, random inputs -> pc=0, carry=0, loads=0, state=00, alu_out=0.
//  2 ROM[0]=8'h33, run=1 -> cycle3: load_a=1, alu_out=3; after: pc=1, carry=0, load_a=0.
//  3 ROM[0]=8'h01, reg_a=4'hF; ROM[1]=8'hE5 -> alu_out=0, carry=1; JNC not taken, pc=2,
//    carry cleared to 0 after JNC EXEC.
//  4 ROM[0]=8'h05 (reg_a=2), ROM[1]=8'hE9 -> carry=0, JNC taken, pc=9; ROM[15]=NOP -> pc wraps to 0.
//  5 run=0 for 10 cycles -> state stays 00, pc stable, no loads; run=1 resumes at same pc.
//  6 ROM[0]=8'hB9 then clr=1 during DECODE -> next state FETCH, pc=0, load_out never asserted.

Source files
------------

// File: rtl/td4_sequencer.sv
// td4_sequencer: fetch/decode/execute control stage of the 4-bit TD4-style CPU.
// Owns PC, IR, the 4-bit adder and the carry flag; every instruction takes
// exactly three clocks (FETCH, DECODE, EXEC). Load strobes are registered and
// only ever high while the FSM sits in EXEC.
module td4_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic [7:0]        rom_data,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  input  logic [DATA_W-1:0] in_port,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] alu_out,
  output logic              load_a,
  output logic              load_b,
  output logic              load_out,
  output logic              carry,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD_A_IM = 4'b0000,
    OP_MOV_A_B  = 4'b0001,
    OP_IN_A     = 4'b0010,
    OP_MOV_A_IM = 4'b0011,
    OP_MOV_B_A  = 4'b0100,
    OP_ADD_B_IM = 4'b0101,
    OP_IN_B     = 4'b0110,
    OP_MOV_B_IM = 4'b0111,
    OP_OUT_B    = 4'b1001,
    OP_OUT_IM   = 4'b1011,
    OP_JNC      = 4'b1110,
    OP_JMP      = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_A    = 2'd1,
    DEST_B    = 2'd2,
    DEST_OUT  = 2'd3
  } dest_e;

  state_e            st;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic              cy_next;

  opcode_e           op;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] src;
  dest_e             dest;
  logic [DATA_W:0]   sum;
  logic              jump_taken;

  assign rom_addr = pc;
  assign state    = st;

  // Decode the held instruction: operand source, destination and adder result.
  always_comb begin
    op         = opcode_e'(ir[7:4]);
    imm        = ir[DATA_W-1:0];
    src        = '0;
    dest       = DEST_NONE;
    jump_taken = 1'b0;
    case (op)
      OP_ADD_A_IM: begin src = reg_a;   dest = DEST_A;   end
      OP_MOV_A_B:  begin src = reg_b;   dest = DEST_A;   end
      OP_IN_A:     begin src = in_port; dest = DEST_A;   end
      OP_MOV_A_IM: begin src = '0;      dest = DEST_A;   end
      OP_MOV_B_A:  begin src = reg_a;   dest = DEST_B;   end
      OP_ADD_B_IM: begin src = reg_b;   dest = DEST_B;   end
      OP_IN_B:     begin src = in_port; dest = DEST_B;   end
      OP_MOV_B_IM: begin src = '0;      dest = DEST_B;   end
      OP_OUT_B:    begin src = reg_b;   dest = DEST_OUT; end
      OP_OUT_IM:   begin src = '0;      dest = DEST_OUT; end
      OP_JMP:      jump_taken = 1'b1;
      OP_JNC:      jump_taken = ~carry;
      default:     ;
    endcase
    sum = {1'b0, src} + {1'b0, imm};
  end

  // Sequencer FSM with registered datapath outputs and strobes; clr overrides all.
  always_ff @(posedge clk) begin
    if (clr) begin
      st       <= FETCH;
      pc       <= '0;
      ir       <= '0;
      alu_out  <= '0;
      carry    <= 1'b0;
      cy_next  <= 1'b0;
      load_a   <= 1'b0;
      load_b   <= 1'b0;
      load_out <= 1'b0;
    end else begin
      case (st)
        FETCH: begin
          if (run) begin
            ir <= rom_data;
            st <= DECODE;
          end
        end
        DECODE: begin
          alu_out  <= sum[DATA_W-1:0];
          cy_next  <= sum[DATA_W];
          load_a   <= (dest == DEST_A);
          load_b   <= (dest == DEST_B);
          load_out <= (dest == DEST_OUT);
          st       <= EXEC;
        end
        EXEC: begin
          load_a   <= 1'b0;
          load_b   <= 1'b0;
          load_out <= 1'b0;
          carry    <= cy_next;
          // JNC looks at the flag before this EXEC updates it.
          if (jump_taken) pc <= ADDR_W'(imm);
          else            pc <= pc + 1'b1;
          st       <= FETCH;
        end
        default: st <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_sequencer.sv
// Testbench for td4_sequencer: directed scenarios plus random programs, checked
// against an instruction-level reference model (pc, carry, per-instruction result).
module tb_td4_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic       run;
  logic [7:0] rom_data;
  logic [3:0] reg_a, reg_b, in_port;
  logic [3:0] rom_addr;
  logic [3:0] alu_out;
  logic       load_a, load_b, load_out, carry;
  logic [1:0] state;

  logic [7:0] rom [16];
  int n_checks = 0;
  int n_fail   = 0;

  int m_pc;
  int m_carry;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  td4_sequencer #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk(clk), .clr(clr), .run(run), .rom_data(rom_data),
    .reg_a(reg_a), .reg_b(reg_b), .in_port(in_port),
    .rom_addr(rom_addr), .alu_out(alu_out),
    .load_a(load_a), .load_b(load_b), .load_out(load_out),
    .carry(carry), .state(state)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    reg_a   = 4'($urandom);
    reg_b   = 4'($urandom);
    in_port = 4'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 8'(state), 8'h0);
    check({tag, "_pc"}, 8'(rom_addr), 8'h0);
    check({tag, "_carry"}, 8'(carry), 8'h0);
    check({tag, "_loads"}, 8'({load_a, load_b, load_out}), 8'h0);
    check({tag, "_alu"}, 8'(alu_out), 8'h0);
  endtask

  task automatic reset_dut();
    clr = 1'b1;
    run = 1'($urandom);
    rand_inputs();
    tick();
    run = 1'($urandom);
    rand_inputs();
    tick();
    check_reset_state("rst");
    clr = 1'b0;
    m_pc = 0;
    m_carry = 0;
  endtask

  // One instruction at the model level: source value, destination and next pc
  // follow directly from the opcode table.
  task automatic step_instr(input bit fixed, input logic [3:0] a_v, b_v, in_v,
                            input int max_idle);
    logic [7:0] w;
    int op, imm, srcv, sum, dest, idle, next_pc;
    w    = rom[m_pc];
    op   = int'(w[7:4]);
    imm  = int'(w[3:0]);
    idle = $urandom_range(0, max_idle);
    repeat (idle) begin
      run = 1'b0;
      rand_inputs();
      tick();
      check("idle_state", 8'(state), 8'h0);
      check("idle_pc", 8'(rom_addr), 8'(m_pc));
    end
    run = 1'b1;
    tick();
    check("fetch_state", 8'(state), 8'h1);
    check("fetch_loads", 8'({load_a, load_b, load_out}), 8'h0);
    if (fixed) begin
      reg_a = a_v; reg_b = b_v; in_port = in_v;
    end else begin
      rand_inputs();
    end
    srcv = 0;
    dest = 0;
    case (op)
      0:  begin srcv = int'(reg_a);   dest = 1; end
      1:  begin srcv = int'(reg_b);   dest = 1; end
      2:  begin srcv = int'(in_port); dest = 1; end
      3:  begin srcv = 0;             dest = 1; end
      4:  begin srcv = int'(reg_a);   dest = 2; end
      5:  begin srcv = int'(reg_b);   dest = 2; end
      6:  begin srcv = int'(in_port); dest = 2; end
      7:  begin srcv = 0;             dest = 2; end
      9:  begin srcv = int'(reg_b);   dest = 3; end
      11: begin srcv = 0;             dest = 3; end
      default: begin srcv = 0;        dest = 0; end
    endcase
    sum = srcv + imm;
    run = 1'($urandom);
    tick();
    check("exec_state", 8'(state), 8'h2);
    check("exec_alu", 8'(alu_out), 8'(sum % 16));
    check("exec_loads", 8'({load_a, load_b, load_out}),
          8'({dest == 1, dest == 2, dest == 3}));
    check("exec_carry_old", 8'(carry), 8'(m_carry));
    rand_inputs();
    run = 1'($urandom);
    if (op == 15)                      next_pc = imm;
    else if (op == 14 && m_carry == 0) next_pc = imm;
    else                               next_pc = (m_pc + 1) % 16;
    m_carry = sum / 16;
    m_pc    = next_pc;
    tick();
    check("done_state", 8'(state), 8'h0);
    check("done_loads", 8'({load_a, load_b, load_out}), 8'h0);
    check("done_carry", 8'(carry), 8'(m_carry));
    check("done_pc", 8'(rom_addr), 8'(m_pc));
  endtask

  // Start an instruction and hit clr in DECODE (phase 0) or EXEC (phase 1).
  task automatic abort_instr(input int phase);
    run = 1'b1;
    rand_inputs();
    tick();
    if (phase == 1) tick();
    clr = 1'b1;
    rand_inputs();
    tick();
    check_reset_state("abort");
    clr = 1'b0;
    m_pc = 0;
    m_carry = 0;
  endtask

  initial begin
    clr = 1'b0;
    run = 1'b0;
    reg_a = '0; reg_b = '0; in_port = '0;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);

    // 1: reset with random inputs
    reset_dut();

    // 2: MOV A,3
    rom[0] = 8'h33;
    step_instr(1'b1, 4'h0, 4'h0, 4'h0, 0);
    check("t2_pc", 8'(rom_addr), 8'h01);
    check("t2_load_a", 8'(load_a), 8'h0);

    // 3: ADD A,1 with A=F sets carry; JNC not taken and clears carry
    reset_dut();
    rom[0] = 8'h01;
    rom[1] = 8'hE5;
    step_instr(1'b1, 4'hF, 4'h0, 4'h0, 0);
    check("t3_carry", 8'(carry), 8'h1);
    step_instr(1'b1, 4'h0, 4'h0, 4'h0, 0);
    check("t3_pc", 8'(rom_addr), 8'h02);
    check("t3_carry_clr", 8'(carry), 8'h0);

    // 4: ADD A,5 with A=2, JNC taken to 9, JMP 15, NOP at 15 wraps pc
    reset_dut();
    rom[0]  = 8'h05;
    rom[1]  = 8'hE9;
    rom[9]  = 8'hFF;
    rom[15] = 8'h80;
    step_instr(1'b1, 4'h2, 4'h0, 4'h0, 0);
    step_instr(1'b1, 4'h0, 4'h0, 4'h0, 0);
    check("t4_pc_jnc", 8'(rom_addr), 8'h09);
    step_instr(1'b0, 4'h0, 4'h0, 4'h0, 0);
    step_instr(1'b0, 4'h0, 4'h0, 4'h0, 0);
    check("t4_pc_wrap", 8'(rom_addr), 8'h00);

    // 5: run low holds FETCH, then resumes at the same pc
    step_instr(1'b0, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 10; i++) begin
      run = 1'b0;
      rand_inputs();
      tick();
      check("t5_state", 8'(state), 8'h0);
      check("t5_pc", 8'(rom_addr), 8'(m_pc));
      check("t5_loads", 8'({load_a, load_b, load_out}), 8'h0);
    end
    step_instr(1'b0, 4'h0, 4'h0, 4'h0, 0);

    // 6: OUT 9 aborted by clr in DECODE never strobes load_out
    reset_dut();
    rom[0] = 8'hB9;
    abort_instr(0);
    for (int i = 0; i < 3; i++) begin
      run = 1'b0;
      tick();
      check("t6_load_out", 8'(load_out), 8'h0);
      check("t6_pc", 8'(rom_addr), 8'h0);
    end

    // Random programs with idle gaps and occasional aborts
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    for (int n = 0; n < 400; n++) begin
      if (n == 200)
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      if ($urandom_range(0, 30) == 0) abort_instr(int'($urandom_range(0, 1)));
      else step_instr(1'b0, 4'h0, 4'h0, 4'h0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
